mem_xfer_fsm: RTL and testbench

//   Parametrised load/store bus controller, successor to the single-word load/store FSM.

---
 rtl/mem_xfer_pkg.sv | 27 ++
 rtl/mfc_watchdog.sv | 27 ++
 rtl/mem_xfer_fsm.sv | 155 +++++++++++++++
 tb/tb_mem_xfer_fsm.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared opcodes, FSM state encoding and register-select helpers for the memory transfer controller.
package mem_xfer_pkg;

    localparam logic [3:0] OP_LOAD  = 4'hB;
    localparam logic [3:0] OP_STORE = 4'hC;

    typedef enum logic [3:0] {
        IDLE,
        DECODE,
        LATCH_MAR,
        REG_TO_BUS,
        MDR_FROM_BUS,
        MEM_REQ,
        WAIT_MFC,
        MDR_FROM_MEM,
        MDR_TO_BUS,
        REG_LATCH,
        MEM_WR_END,
        ERROR
    } state_t;

    // All-ones register select means "no register" on regIn/regOut.
    function automatic int unsigned regNone(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/mfc_watchdog.sv
// Counts cycles spent waiting for MFC and flags expiry on the MFC_TIMEOUT-th cycle.
// Held at zero while not enabled, so every wait starts from a fresh count; MFC_TIMEOUT=0 disables it.
module mfc_watchdog #(
    parameter int MFC_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (MFC_TIMEOUT < 2) ? 1 : $clog2(MFC_TIMEOUT);

    logic [CW-1:0] cnt;

    assign expired = (MFC_TIMEOUT != 0) && en && (cnt == CW'(MFC_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_xfer_fsm.sv
// Burst load/store bus controller: drives MAR/MDR/register strobes for 1..2^BURST_W words.
// Registered Moore outputs; 1-word load start->done 7 cycles, ignores start while busy.
module mem_xfer_fsm #(
    parameter int         ADDR_W      = 16,
    parameter int         REG_SEL_W   = 6,
    parameter int         BURST_W     = 4,
    parameter int         MFC_TIMEOUT = 255,
    parameter logic [3:0] OP_LOAD     = mem_xfer_pkg::OP_LOAD,
    parameter logic [3:0] OP_STORE    = mem_xfer_pkg::OP_STORE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           opCode,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [REG_SEL_W-1:0] reg_sel,
    input  logic [BURST_W-1:0]   burst_len,
    input  logic                 MFC,
    output logic [ADDR_W-1:0]    address,
    output logic                 marIn,
    output logic                 marOut,
    output logic                 MemEN,
    output logic                 RW,
    output logic                 readFromMem,
    output logic                 outToBus,
    output logic                 readFromBus,
    output logic                 outToMem,
    output logic [REG_SEL_W-1:0] regIn,
    output logic [REG_SEL_W-1:0] regOut,
    output logic                 incr,
    output logic                 fetch,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    import mem_xfer_pkg::*;

    localparam logic [REG_SEL_W-1:0] REG_NONE = REG_SEL_W'(regNone(REG_SEL_W));

    state_t                state, nextState;
    logic [ADDR_W-1:0]     curAddr, nxtAddr;
    logic [REG_SEL_W-1:0]  curReg, nxtReg, regInc;
    logic [BURST_W-1:0]    beat, nxtBeat, len, nxtLen;
    logic                  isLoad, nxtLoad, nxtLast, validStart, mfcExpired, addrEn;

    assign validStart = start && ((opCode == OP_LOAD) || (opCode == OP_STORE));
    assign regInc     = curReg + 1'b1;
    assign address    = addrEn ? curAddr : {ADDR_W{1'bz}};

    mfc_watchdog #(.MFC_TIMEOUT(MFC_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != WAIT_MFC),
        .en      (state == WAIT_MFC),
        .expired (mfcExpired)
    );

    always_comb begin
        nextState = state;
        nxtAddr   = curAddr;
        nxtReg    = curReg;
        nxtBeat   = beat;
        nxtLen    = len;
        nxtLoad   = isLoad;
        case (state)
            IDLE: if (validStart) begin
                nextState = DECODE;
                nxtAddr   = addr_in;
                nxtReg    = reg_sel;
                nxtLen    = burst_len;
                nxtBeat   = '0;
                nxtLoad   = (opCode == OP_LOAD);
            end
            DECODE:       nextState = LATCH_MAR;
            LATCH_MAR:    nextState = isLoad ? MEM_REQ : REG_TO_BUS;
            REG_TO_BUS:   nextState = MDR_FROM_BUS;
            MDR_FROM_BUS: nextState = MEM_REQ;
            MEM_REQ:      nextState = WAIT_MFC;
            // MFC takes priority over a watchdog expiry in the same cycle
            WAIT_MFC: begin
                if (MFC)             nextState = isLoad ? MDR_FROM_MEM : MEM_WR_END;
                else if (mfcExpired) nextState = ERROR;
            end
            MDR_FROM_MEM: nextState = MDR_TO_BUS;
            MDR_TO_BUS:   nextState = REG_LATCH;
            REG_LATCH, MEM_WR_END: begin
                if (beat == len) begin
                    nextState = IDLE;
                end else begin
                    nextState = LATCH_MAR;
                    nxtAddr   = curAddr + 1'b1;
                    nxtReg    = (regInc == REG_NONE) ? '0 : regInc;
                    nxtBeat   = beat + 1'b1;
                end
            end
            ERROR:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
        nxtLast = (nxtBeat == nxtLen);
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            curAddr     <= '0;
            curReg      <= '0;
            beat        <= '0;
            len         <= '0;
            isLoad      <= 1'b0;
            addrEn      <= 1'b0;
            marIn       <= 1'b0;
            marOut      <= 1'b0;
            MemEN       <= 1'b0;
            RW          <= 1'b0;
            readFromMem <= 1'b0;
            outToBus    <= 1'b0;
            readFromBus <= 1'b0;
            outToMem    <= 1'b0;
            regIn       <= REG_NONE;
            regOut      <= REG_NONE;
            incr        <= 1'b0;
            fetch       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= nextState;
            curAddr     <= nxtAddr;
            curReg      <= nxtReg;
            beat        <= nxtBeat;
            len         <= nxtLen;
            isLoad      <= nxtLoad;
            addrEn      <= (nextState == LATCH_MAR);
            marIn       <= (nextState == LATCH_MAR);
            incr        <= (nextState == LATCH_MAR) && (nxtBeat == '0);
            marOut      <= (nextState == MEM_REQ) || (nextState == WAIT_MFC);
            MemEN       <= (nextState == MEM_REQ) || (nextState == WAIT_MFC);
            RW          <= ((nextState == MEM_REQ) || (nextState == WAIT_MFC)) && nxtLoad;
            outToMem    <= (nextState == MEM_REQ) || (nextState == WAIT_MFC) ||
                           (nextState == MEM_WR_END);
            readFromMem <= (nextState == MDR_FROM_MEM);
            outToBus    <= (nextState == MDR_TO_BUS) || (nextState == REG_LATCH);
            readFromBus <= (nextState == MDR_FROM_BUS);
            regOut      <= ((nextState == REG_TO_BUS) || (nextState == MDR_FROM_BUS)) ?
                           nxtReg : REG_NONE;
            regIn       <= (nextState == REG_LATCH) ? nxtReg : REG_NONE;
            done        <= ((nextState == REG_LATCH) || (nextState == MEM_WR_END)) && nxtLast;
            fetch       <= ((nextState == REG_LATCH) || (nextState == MEM_WR_END)) && nxtLast;
            busy        <= (nextState != IDLE);
            err         <= (nextState == ERROR);
        end
    end

endmodule

// File: tb/tb_mem_xfer_fsm.sv
// Directed, table-driven bench for mem_xfer_fsm plus hand sequences for reset handling.
module tb_mem_xfer_fsm;

    logic        clk = 1'b0;
    logic        reset, start, MFC;
    logic [3:0]  opCode;
    logic [15:0] addr_in;
    logic [5:0]  reg_sel;
    logic [3:0]  burst_len;
    wire  [15:0] address;
    logic        marIn, marOut, MemEN, RW, readFromMem, outToBus, readFromBus, outToMem;
    logic [5:0]  regIn, regOut;
    logic        incr, fetch, busy, done, err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_xfer_fsm #(
        .ADDR_W(16), .REG_SEL_W(6), .BURST_W(4), .MFC_TIMEOUT(4),
        .OP_LOAD(4'hB), .OP_STORE(4'hC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .opCode(opCode), .addr_in(addr_in),
        .reg_sel(reg_sel), .burst_len(burst_len), .MFC(MFC), .address(address),
        .marIn(marIn), .marOut(marOut), .MemEN(MemEN), .RW(RW), .readFromMem(readFromMem),
        .outToBus(outToBus), .readFromBus(readFromBus), .outToMem(outToMem),
        .regIn(regIn), .regOut(regOut), .incr(incr), .fetch(fetch), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] addr;
        logic [5:0]  rsel;
        logic [3:0]  len;
        bit          mfcOn;
        int          holdStart;   // keep a conflicting start asserted for n < holdStart
        int          expCycles;   // 0 = latency not checked
        int          expDone;
        int          expErr;
        int          expBeats;
        logic [15:0] expAddrLast;
        logic [5:0]  expRegLast;
        bit          regChk;
        bit          expRW;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] strobes();
        return {marIn, marOut, MemEN, RW, readFromMem, outToBus, readFromBus, outToMem,
                incr, fetch, done, err, busy};
    endfunction

    task automatic runXfer(input vec_t v, input int idx);
        int beats = 0, incrs = 0, dones = 0, fetches = 0, errs = 0, rwBad = 0;
        int endCycle = 0;
        bit anyBusy = 0;
        logic [15:0] firstAddr = '0, lastAddr = '0;
        logic [5:0]  firstReg = '0, lastReg = '0;
        int regs = 0;
        @(negedge clk);
        start = 1'b1; opCode = v.op; addr_in = v.addr; reg_sel = v.rsel;
        burst_len = v.len; MFC = 1'b0;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (busy) anyBusy = 1;
            if (marIn) begin
                beats++;
                if (beats == 1) firstAddr = address;
                lastAddr = address;
            end
            if (incr)    incrs++;
            if (fetch)   fetches++;
            if (done)    begin dones++; endCycle = n; end
            if (err)     begin errs++;  endCycle = n; end
            if (RW && !MemEN) rwBad++;
            if (MemEN && (RW !== v.expRW)) rwBad++;
            if ((v.op == 4'hB && regIn != 6'h3F) || (v.op == 4'hC && readFromBus)) begin
                regs++;
                if (regs == 1) firstReg = (v.op == 4'hB) ? regIn : regOut;
                lastReg = (v.op == 4'hB) ? regIn : regOut;
            end
            if (n < v.holdStart) begin
                start = 1'b1; opCode = 4'hC; addr_in = 16'h7777; reg_sel = 6'd20; burst_len = 4'd5;
            end else begin
                start = 1'b0; opCode = 4'($urandom); addr_in = 16'($urandom);
                reg_sel = 6'($urandom); burst_len = 4'($urandom);
            end
            MFC = v.mfcOn && MemEN;
            if (n >= 3 && !busy) break;
        end
        MFC = 1'b0;
        check($sformatf("v%0d_idle_at_end", idx), busy, 0);
        check($sformatf("v%0d_done_count", idx), dones, v.expDone);
        check($sformatf("v%0d_fetch_count", idx), fetches, v.expDone);
        check($sformatf("v%0d_err_count", idx), errs, v.expErr);
        check($sformatf("v%0d_beats", idx), beats, v.expBeats);
        check($sformatf("v%0d_incr_count", idx), incrs, (v.expBeats > 0) ? 1 : 0);
        check($sformatf("v%0d_rw_bad", idx), rwBad, 0);
        if (v.expCycles != 0)
            check($sformatf("v%0d_latency", idx), endCycle, v.expCycles);
        if (v.expBeats > 0) begin
            check($sformatf("v%0d_first_addr", idx), firstAddr, v.addr);
            check($sformatf("v%0d_last_addr", idx), lastAddr, v.expAddrLast);
        end else begin
            check($sformatf("v%0d_never_busy", idx), anyBusy, 0);
        end
        if (v.regChk) begin
            check($sformatf("v%0d_first_reg", idx), firstReg, v.rsel);
            check($sformatf("v%0d_last_reg", idx), lastReg, v.expRegLast);
            check($sformatf("v%0d_reg_beats", idx), regs, v.expBeats);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_strobes"}, strobes(), 0);
        check({tag, "_regIn"}, regIn, 6'h3F);
        check({tag, "_regOut"}, regOut, 6'h3F);
    endtask

    initial begin
        int memCnt;
        int errSeen;
        reset = 1'b0; start = 1'b0; MFC = 1'b0; opCode = 4'h0;
        addr_in = '0; reg_sel = '0; burst_len = '0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b1;
        @(negedge clk);
        checkIdleOutputs("post_reset");

        //          op     addr      rsel   len  mfc hold cyc dn er bt lastAddr  lastReg chk rw
        vecs[0] = '{4'hB, 16'h0040, 6'd3,  4'd0, 1, 0,  7,  1, 0, 1, 16'h0040, 6'd3,  1, 1};
        vecs[1] = '{4'hC, 16'h0100, 6'd5,  4'd2, 1, 0,  0,  1, 0, 3, 16'h0102, 6'd7,  1, 0};
        vecs[2] = '{4'hB, 16'hFFFF, 6'd62, 4'd1, 1, 0,  13, 1, 0, 2, 16'h0000, 6'd0,  1, 1};
        vecs[3] = '{4'hB, 16'h1234, 6'd10, 4'd0, 0, 0,  8,  0, 1, 1, 16'h1234, 6'd0,  0, 1};
        vecs[4] = '{4'h3, 16'h0040, 6'd3,  4'd0, 1, 0,  0,  0, 0, 0, 16'h0000, 6'd0,  0, 0};
        vecs[5] = '{4'hC, 16'h0010, 6'd1,  4'd0, 1, 0,  0,  1, 0, 1, 16'h0010, 6'd1,  1, 0};
        vecs[6] = '{4'hB, 16'h0040, 6'd3,  4'd0, 1, 6,  7,  1, 0, 1, 16'h0040, 6'd3,  1, 1};
        for (int i = 0; i < 7; i++) runXfer(vecs[i], i);

        // Reset asserted while stalled in WAIT_MFC: abort without done or err.
        @(negedge clk);
        start = 1'b1; opCode = 4'hB; addr_in = 16'h0050; reg_sel = 6'd2; burst_len = 4'd0;
        memCnt = 0;
        for (int n = 0; n < 20 && memCnt < 2; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (MemEN) memCnt++;
        end
        check("rst_reached_wait", memCnt, 2);
        reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("rst_mid_wait");
        reset = 1'b1;
        errSeen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (err || done || busy) errSeen++;
        end
        check("rst_no_late_activity", errSeen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
